q_update_engine: RTL and testbench

- Computes the Q-learning update Q_new = Q(s,a) + alpha*(R + gamma*max Q(s',·) − Q(s,a)) for the traffic-light agent.
- Sits directly upstream of the memory input interface and supplies its Q_new, action, state and write-enable.
- Fully pipelined: accepts one update per cycle, no backpressure, fixed 4-cycle latency.

---
 rtl/q_pkg.sv | 30 +++
 rtl/q_update_engine_row_max.sv | 24 ++
 rtl/q_update_engine.sv | 162 ++++++++++++++++
 tb/tb_q_update_engine.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_pkg.sv
// Shared constants and helpers for the Q-learning update engine.
//   Default widths, action field split, fixed pipeline latency,
//   and a generic signed saturation helper.
package q_pkg;

   localparam int unsigned L_WIDTH_DEF  = 4;
   localparam int unsigned Q_WIDTH_DEF  = 16;
   localparam int unsigned N_LEVEL      = 2**(L_WIDTH_DEF/2);
   localparam int unsigned A_ROAD_WIDTH = 2;
   localparam int unsigned A_DUR_WIDTH  = L_WIDTH_DEF/2;
   localparam int unsigned D_WIDTH      = Q_WIDTH_DEF*N_LEVEL;
   localparam int unsigned N_ROAD       = 4;
   localparam int unsigned QUPD_LAT     = 4;
   localparam int unsigned SAT_W        = 64;

   // Clamp a wide signed value into the signed range of a w-bit number.
   function automatic logic signed [SAT_W-1:0] sat_signed(
      input logic signed [SAT_W-1:0] x,
      input int unsigned             w
   );
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (x > hi)      return hi;
      else if (x < lo) return lo;
      else             return x;
   endfunction

endpackage

// File: rtl/q_update_engine_row_max.sv
// Combinational signed maximum of the N_LEVEL Q-value fields of one row.
//   row   : N_LEVEL packed Q_WIDTH fields, field i at bits [i*Q_WIDTH +: Q_WIDTH]
//   max_c : signed maximum of the fields
module row_max
   import q_pkg::*;
#(
   parameter int unsigned Q_WIDTH = Q_WIDTH_DEF,
   parameter int unsigned N_LEVEL = 4
) (
   input  logic [Q_WIDTH*N_LEVEL-1:0] row,
   output logic signed [Q_WIDTH-1:0]  max_c
);

   // Linear scan; only the value matters so tie order is irrelevant.
   always_comb begin
      max_c = row[Q_WIDTH-1:0];
      for (int unsigned i = 1; i < N_LEVEL; i++) begin
         if ($signed(row[i*Q_WIDTH +: Q_WIDTH]) > max_c) begin
            max_c = row[i*Q_WIDTH +: Q_WIDTH];
         end
      end
   end

endmodule

// File: rtl/q_update_engine.sv
// Four-stage pipelined Q-learning update:
//   Q_new = sat(Q(s,a) + alpha*(R + gamma*max Q(s',.) - Q(s,a)))
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid, flush   : input strobe, synchronous drop of all in-flight updates
//   cnt_clr           : synchronous clear of upd_cnt (wins over increment)
//   A, S, R, term     : action {road,dur}, state, signed reward, terminal s'
//   D_cur0..3         : current-state rows per road, D_nxt0..3 : next-state rows
//   Q_new, A_out, S_out, out_valid : aligned result, out_valid is the write enable
//   upd_cnt           : number of out_valid pulses, wraps
module q_update_engine
   import q_pkg::*;
#(
   parameter int unsigned L_WIDTH     = L_WIDTH_DEF,
   parameter int unsigned Q_WIDTH     = Q_WIDTH_DEF,
   parameter int unsigned R_WIDTH     = 16,
   parameter int unsigned ALPHA_SHIFT = 3,
   parameter int unsigned GAMMA_SHIFT = 3,
   parameter int unsigned CNT_WIDTH   = 32
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   in_valid,
   input  logic                                   flush,
   input  logic                                   cnt_clr,
   input  logic [L_WIDTH/2+A_ROAD_WIDTH-1:0]      A,
   input  logic [2*L_WIDTH-1:0]                   S,
   input  logic signed [R_WIDTH-1:0]              R,
   input  logic                                   term,
   input  logic [Q_WIDTH*(2**(L_WIDTH/2))-1:0]    D_cur0,
   input  logic [Q_WIDTH*(2**(L_WIDTH/2))-1:0]    D_cur1,
   input  logic [Q_WIDTH*(2**(L_WIDTH/2))-1:0]    D_cur2,
   input  logic [Q_WIDTH*(2**(L_WIDTH/2))-1:0]    D_cur3,
   input  logic [Q_WIDTH*(2**(L_WIDTH/2))-1:0]    D_nxt0,
   input  logic [Q_WIDTH*(2**(L_WIDTH/2))-1:0]    D_nxt1,
   input  logic [Q_WIDTH*(2**(L_WIDTH/2))-1:0]    D_nxt2,
   input  logic [Q_WIDTH*(2**(L_WIDTH/2))-1:0]    D_nxt3,
   output logic signed [Q_WIDTH-1:0]              Q_new,
   output logic [L_WIDTH/2+A_ROAD_WIDTH-1:0]      A_out,
   output logic [2*L_WIDTH-1:0]                   S_out,
   output logic                                   out_valid,
   output logic [CNT_WIDTH-1:0]                   upd_cnt
);

   localparam int unsigned N_LEV = 2**(L_WIDTH/2);
   localparam int unsigned DUR_W = L_WIDTH/2;
   localparam int unsigned A_W   = DUR_W + A_ROAD_WIDTH;
   localparam int unsigned S_W   = 2*L_WIDTH;
   localparam int unsigned D_W   = Q_WIDTH*N_LEV;
   localparam int unsigned T_W   = Q_WIDTH + 3;

   logic [D_W-1:0]            cur_rows  [N_ROAD];
   logic [D_W-1:0]            nxt_rows  [N_ROAD];
   logic signed [Q_WIDTH-1:0] row_max_c [N_ROAD];
   logic [A_ROAD_WIDTH-1:0]   road_c;
   logic [DUR_W-1:0]          dur_c;
   logic signed [Q_WIDTH-1:0] q_sel_c;
   logic signed [Q_WIDTH-1:0] m_all_c;
   logic signed [T_W-1:0]     td_c;
   logic signed [T_W-1:0]     sum_c;
   logic signed [Q_WIDTH-1:0] q_new_c;

   logic [QUPD_LAT-1:0]       v;
   logic signed [Q_WIDTH-1:0] q_c0, q_c1, q_c2;
   logic signed [Q_WIDTH-1:0] m0 [N_ROAD];
   logic signed [Q_WIDTH-1:0] m1;
   logic signed [Q_WIDTH-1:0] r0, r1;
   logic signed [T_W-1:0]     td2;
   logic                      term0;
   logic [A_W-1:0]            a0, a1, a2;
   logic [S_W-1:0]            s0, s1, s2;

   assign cur_rows[0] = D_cur0;
   assign cur_rows[1] = D_cur1;
   assign cur_rows[2] = D_cur2;
   assign cur_rows[3] = D_cur3;
   assign nxt_rows[0] = D_nxt0;
   assign nxt_rows[1] = D_nxt1;
   assign nxt_rows[2] = D_nxt2;
   assign nxt_rows[3] = D_nxt3;

   // Per-road maximum of the next-state rows.
   for (genvar r = 0; r < N_ROAD; r++) begin : g_row
      row_max #(.Q_WIDTH(Q_WIDTH), .N_LEVEL(N_LEV)) u_row_max (
         .row   (nxt_rows[r]),
         .max_c (row_max_c[r])
      );
   end

   // Current Q(s,a) selected by road and duration fields of the action.
   assign road_c  = A[A_W-1 -: A_ROAD_WIDTH];
   assign dur_c   = A[DUR_W-1:0];
   assign q_sel_c = cur_rows[road_c][dur_c*Q_WIDTH +: Q_WIDTH];

   // Maximum across roads of the stage-0 per-road maxima.
   always_comb begin
      m_all_c = m0[0];
      for (int unsigned r = 1; r < N_ROAD; r++) begin
         if (m0[r] > m_all_c) m_all_c = m0[r];
      end
   end

   // Wide temporal difference: gamma*M realised as M - (M >>> GAMMA_SHIFT).
   assign td_c    = T_W'(r1) + T_W'(m1) - T_W'(m1 >>> GAMMA_SHIFT) - T_W'(q_c1);
   assign sum_c   = T_W'(q_c2) + (td2 >>> ALPHA_SHIFT);
   assign q_new_c = Q_WIDTH'(sat_signed(SAT_W'(sum_c), Q_WIDTH));

   // Valid shift chain and payload pipeline; payload loads every cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v     <= '0;
         q_c0  <= '0;
         q_c1  <= '0;
         q_c2  <= '0;
         for (int unsigned r = 0; r < N_ROAD; r++) m0[r] <= '0;
         m1    <= '0;
         r0    <= '0;
         r1    <= '0;
         td2   <= '0;
         term0 <= 1'b0;
         a0    <= '0;
         a1    <= '0;
         a2    <= '0;
         s0    <= '0;
         s1    <= '0;
         s2    <= '0;
         Q_new <= '0;
         A_out <= '0;
         S_out <= '0;
      end else begin
         v     <= flush ? '0 : {v[QUPD_LAT-2:0], in_valid};
         q_c0  <= q_sel_c;
         for (int unsigned r = 0; r < N_ROAD; r++) m0[r] <= row_max_c[r];
         r0    <= Q_WIDTH'(R);
         term0 <= term;
         a0    <= A;
         s0    <= S;
         m1    <= term0 ? '0 : m_all_c;
         q_c1  <= q_c0;
         r1    <= r0;
         a1    <= a0;
         s1    <= s0;
         td2   <= td_c;
         q_c2  <= q_c1;
         a2    <= a1;
         s2    <= s1;
         Q_new <= q_new_c;
         A_out <= a2;
         S_out <= s2;
      end
   end

   assign out_valid = v[QUPD_LAT-1];

   // Update counter; clear wins over increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           upd_cnt <= '0;
      else if (cnt_clr)   upd_cnt <= '0;
      else if (out_valid) upd_cnt <= upd_cnt + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_q_update_engine.sv
// Self-checking bench for q_update_engine with a plain-arithmetic reference model.
module tb_q_update_engine;

   localparam int QW = 16;
   localparam int NL = 4;
   localparam int DW = QW*NL;
   localparam int AW = 4;
   localparam int SW = 8;
   localparam int RW = 16;
   localparam int CW = 32;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid, flush, cnt_clr, term;
   logic [AW-1:0]        A, A_out;
   logic [SW-1:0]        S, S_out;
   logic signed [RW-1:0] R;
   logic [DW-1:0]        D_cur0, D_cur1, D_cur2, D_cur3;
   logic [DW-1:0]        D_nxt0, D_nxt1, D_nxt2, D_nxt3;
   logic signed [QW-1:0] Q_new;
   logic                 out_valid;
   logic [CW-1:0]        upd_cnt;

   q_update_engine dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .cnt_clr(cnt_clr),
      .A(A), .S(S), .R(R), .term(term),
      .D_cur0(D_cur0), .D_cur1(D_cur1), .D_cur2(D_cur2), .D_cur3(D_cur3),
      .D_nxt0(D_nxt0), .D_nxt1(D_nxt1), .D_nxt2(D_nxt2), .D_nxt3(D_nxt3),
      .Q_new(Q_new), .A_out(A_out), .S_out(S_out), .out_valid(out_valid), .upd_cnt(upd_cnt)
   );

   always #5 clk = ~clk;

   int cur_m [4][NL];
   int nxt_m [4][NL];
   int exp_q [$];
   int exp_a [$];
   int exp_s [$];
   int n_checks = 0;
   int n_fail   = 0;

   // floor(x / 2^sh) for any sign of x
   function automatic int fdiv(input int x, input int sh);
      int d;
      d = 1 << sh;
      if (x >= 0) return x / d;
      return -((-x + d - 1) / d);
   endfunction

   function automatic int model_q(input int a, input int r, input bit t);
      int qc, m, td, q;
      qc = cur_m[a / NL][a % NL];
      m  = nxt_m[0][0];
      foreach (nxt_m[i, j]) if (nxt_m[i][j] > m) m = nxt_m[i][j];
      if (t) m = 0;
      td = r + m - fdiv(m, 3) - qc;
      q  = qc + fdiv(td, 3);
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return q;
   endfunction

   function automatic int rnd_q();
      return int'($urandom_range(65535)) - 32768;
   endfunction

   task automatic rand_rows();
      foreach (cur_m[i, j]) begin
         cur_m[i][j] = rnd_q();
         nxt_m[i][j] = rnd_q();
      end
   endtask

   task automatic sb_clear();
      exp_q.delete();
      exp_a.delete();
      exp_s.delete();
   endtask

   // Drive one input cycle from the row arrays; record expectation when valid.
   task automatic apply(input int a, input int s, input int r, input bit t, input bit v);
      for (int i = 0; i < NL; i++) begin
         D_cur0[i*QW +: QW] = QW'(cur_m[0][i]);
         D_cur1[i*QW +: QW] = QW'(cur_m[1][i]);
         D_cur2[i*QW +: QW] = QW'(cur_m[2][i]);
         D_cur3[i*QW +: QW] = QW'(cur_m[3][i]);
         D_nxt0[i*QW +: QW] = QW'(nxt_m[0][i]);
         D_nxt1[i*QW +: QW] = QW'(nxt_m[1][i]);
         D_nxt2[i*QW +: QW] = QW'(nxt_m[2][i]);
         D_nxt3[i*QW +: QW] = QW'(nxt_m[3][i]);
      end
      A = AW'(a); S = SW'(s); R = RW'(r); term = t; in_valid = v;
      if (v) begin
         exp_q.push_back(model_q(a, r, t));
         exp_a.push_back(a);
         exp_s.push_back(s);
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
      rand_rows();
      apply(0, 0, 0, 1'b0, 1'b0);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
      n_checks++; if (Q_new !== 16'sd0) begin n_fail++; $display("FAIL reset_q: got %0d want 0", Q_new); end
      n_checks++; if (A_out !== '0 || S_out !== '0) begin n_fail++; $display("FAIL reset_as: got a=%0d s=%0d want 0", A_out, S_out); end
      n_checks++; if (upd_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", upd_cnt); end
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      sb_clear();
      foreach (cur_m[i, j]) begin cur_m[i][j] = 7*(i*NL+j) - 50; nxt_m[i][j] = 3*(i*NL+j) - 20; end
      cur_m[1][2] = 100;
      nxt_m[3][1] = 200;
      apply(6, 8'h5a, 16, 1'b0, 1'b1);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk); idle();
         if (c < 4) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_%0d: got %0b want 0", c, out_valid); end
         end else if (c == 4) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %0b want 1", out_valid); end
            n_checks++; if (Q_new !== 16'sd111) begin n_fail++; $display("FAIL basic_q: got %0d want 111", Q_new); end
            n_checks++; if (A_out !== 4'd6 || S_out !== 8'h5a) begin n_fail++; $display("FAIL basic_as: got a=%0d s=%0h want 6/5a", A_out, S_out); end
         end else begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_single: got %0b want 0", out_valid); end
         end
      end
   endtask

   task automatic test_terminal();
      int s;
      sb_clear();
      rand_rows();
      foreach (cur_m[i, j]) cur_m[i][j] = 20*(i*NL+j) - 150;
      cur_m[2][3] = 8;
      s = int'($urandom_range(255));
      apply(11, s, -40, 1'b1, 1'b1);
      @(negedge clk); idle();
      repeat (3) @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL term_valid: got %0b want 1", out_valid); end
      n_checks++; if (Q_new !== 16'sd2) begin n_fail++; $display("FAIL term_q: got %0d want 2", Q_new); end
      n_checks++; if (A_out !== 4'd11 || S_out !== SW'(s)) begin n_fail++; $display("FAIL term_as: got a=%0d s=%0d want 11/%0d", A_out, S_out, s); end
   endtask

   task automatic test_saturation();
      sb_clear();
      foreach (cur_m[i, j]) begin cur_m[i][j] = 0; nxt_m[i][j] = 32767; end
      cur_m[0][1] = 32760;
      apply(1, 1, 32767, 1'b0, 1'b1);
      @(negedge clk);
      foreach (cur_m[i, j]) begin cur_m[i][j] = 0; nxt_m[i][j] = -32768; end
      cur_m[3][0] = -32768;
      apply(12, 2, -32768, 1'b0, 1'b1);
      @(negedge clk); idle();
      repeat (2) @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || Q_new !== 16'sd32767) begin n_fail++; $display("FAIL sat_pos: got v=%0b q=%0d want 1/32767", out_valid, Q_new); end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || Q_new !== -16'sd32768) begin n_fail++; $display("FAIL sat_neg: got v=%0b q=%0d want 1/-32768", out_valid, Q_new); end
      @(negedge clk);
   endtask

   task automatic test_streaming();
      int eq, ea, es;
      sb_clear();
      cnt_clr = 1'b1; @(negedge clk); cnt_clr = 1'b0;
      n_checks++; if (upd_cnt !== '0) begin n_fail++; $display("FAIL stream_clr: got %0d want 0", upd_cnt); end
      for (int c = 0; c < 12; c++) begin
         if (c < 6) begin
            rand_rows();
            apply(int'($urandom_range(15)), 40 + c, rnd_q(), 1'($urandom_range(1)), 1'b1);
         end else idle();
         @(negedge clk);
         n_checks++;
         if (out_valid !== ((c >= 3 && c <= 8) ? 1'b1 : 1'b0)) begin
            n_fail++; $display("FAIL stream_valid_%0d: got %0b want %0b", c, out_valid, (c >= 3 && c <= 8));
         end else if (out_valid && exp_q.size() == 0) begin
            n_fail++; $display("FAIL stream_extra_%0d: got pulse want none left", c);
         end else if (out_valid) begin
            eq = exp_q.pop_front(); ea = exp_a.pop_front(); es = exp_s.pop_front();
            if (Q_new !== QW'(eq) || A_out !== AW'(ea) || S_out !== SW'(es)) begin
               n_fail++; $display("FAIL stream_data_%0d: got q=%0d a=%0d s=%0d want q=%0d a=%0d s=%0d", c, Q_new, A_out, S_out, eq, ea, es);
            end
         end
      end
      n_checks++; if (upd_cnt !== 32'd6) begin n_fail++; $display("FAIL stream_cnt: got %0d want 6", upd_cnt); end
   endtask

   task automatic test_random();
      bit hist [40];
      int nv, eq, ea, es;
      sb_clear();
      cnt_clr = 1'b1; @(negedge clk); cnt_clr = 1'b0;
      nv = 0;
      for (int c = 0; c < 40; c++) begin
         if (c < 34) begin
            hist[c] = 1'($urandom_range(1));
            rand_rows();
            apply(int'($urandom_range(15)), int'($urandom_range(255)), rnd_q(), 1'($urandom_range(1)), hist[c]);
            if (hist[c]) nv++;
         end else begin
            hist[c] = 1'b0; idle();
         end
         @(negedge clk);
         n_checks++;
         if (out_valid !== ((c >= 3) ? hist[c-3] : 1'b0)) begin
            n_fail++; $display("FAIL rand_valid_%0d: got %0b want %0b", c, out_valid, (c >= 3) ? hist[c-3] : 1'b0);
         end else if (out_valid && exp_q.size() != 0) begin
            eq = exp_q.pop_front(); ea = exp_a.pop_front(); es = exp_s.pop_front();
            if (Q_new !== QW'(eq) || A_out !== AW'(ea) || S_out !== SW'(es)) begin
               n_fail++; $display("FAIL rand_data_%0d: got q=%0d a=%0d s=%0d want q=%0d a=%0d s=%0d", c, Q_new, A_out, S_out, eq, ea, es);
            end
         end
      end
      n_checks++; if (upd_cnt !== CW'(nv)) begin n_fail++; $display("FAIL rand_cnt: got %0d want %0d", upd_cnt, nv); end
   endtask

   task automatic test_flush();
      logic [CW-1:0] cnt0;
      cnt0 = upd_cnt;
      for (int c = 0; c < 3; c++) begin
         rand_rows(); apply(c, c, rnd_q(), 1'b0, 1'b1); @(negedge clk);
      end
      flush = 1'b1; apply(3, 3, 5, 1'b0, 1'b1);
      @(negedge clk); flush = 1'b0; idle();
      for (int c = 0; c < 7; c++) begin
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_%0d: got %0b want 0", c, out_valid); end
         @(negedge clk);
      end
      n_checks++; if (upd_cnt !== cnt0) begin n_fail++; $display("FAIL flush_cnt: got %0d want %0d", upd_cnt, cnt0); end
      sb_clear();
   endtask

   task automatic test_cnt_clr();
      int eq;
      sb_clear();
      rand_rows(); apply(5, 9, rnd_q(), 1'b0, 1'b1);
      @(negedge clk); idle();
      repeat (3) @(negedge clk);
      eq = exp_q.pop_front();
      n_checks++; if (out_valid !== 1'b1 || Q_new !== QW'(eq)) begin n_fail++; $display("FAIL clr_out: got v=%0b q=%0d want 1/%0d", out_valid, Q_new, eq); end
      cnt_clr = 1'b1;
      @(negedge clk); cnt_clr = 1'b0;
      n_checks++; if (upd_cnt !== '0) begin n_fail++; $display("FAIL clr_priority: got %0d want 0", upd_cnt); end
   endtask

   task automatic test_async_reset();
      for (int c = 0; c < 6; c++) begin
         rand_rows(); apply(c + 2, 100 + c, rnd_q(), 1'b0, 1'b1); @(negedge clk);
      end
      n_checks++; if (out_valid !== 1'b1 || upd_cnt === '0) begin n_fail++; $display("FAIL arst_pre: got v=%0b cnt=%0d want 1/nonzero", out_valid, upd_cnt); end
      #2 rst = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || upd_cnt !== '0) begin n_fail++; $display("FAIL arst_now: got v=%0b cnt=%0d want 0/0", out_valid, upd_cnt); end
      n_checks++; if (Q_new !== 16'sd0 || A_out !== '0 || S_out !== '0) begin n_fail++; $display("FAIL arst_data: got q=%0d a=%0d s=%0d want 0", Q_new, A_out, S_out); end
      idle();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_stale_%0d: got %0b want 0", c, out_valid); end
      end
      sb_clear();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_terminal();
      test_saturation();
      test_streaming();
      test_random();
      test_flush();
      test_cnt_clr();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
